rom_reader: RTL and testbench

Sweep controller that acts as the initiator for the team's synchronous `rom` block. On a start request it walks an inclusive address range, drives `en`/`addr` to the ROM, and captures each returned word. It presents each word with its address on a valid/ready output stream and accumulates a running checksum. It sits between the ROM and any consumer that needs sequential table contents, such as a loader, a self-test, or a UART dump.

---
 rtl/rom_reader.sv | 125 ++++++++++++
 tb/tb_rom_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rom_reader.sv
// rtl/rom_reader.sv - sweep controller reading an inclusive address range from a synchronous ROM
//
// Walks first_addr..last_addr (wrapping modulo 2^ADDR_W), issues one ROM read per
// address, presents each word with its address on a valid/ready stream and keeps a
// running checksum of the words the consumer accepted.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin a sweep (sampled only when idle)
//   first_addr, last_addr  inclusive sweep range, latched on start
//   busy, done             sweep in progress / one-cycle completion pulse
//   rom_en, rom_addr       ROM read request
//   rom_data               ROM read data, valid the cycle after the rom_en edge
//   out_valid, out_ready   output word handshake
//   out_data, out_addr     captured word and its address
//   checksum               modulo-2^CSUM_W sum of accepted words
module rom_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int CSUM_W = ADDR_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CSUM_W-1:0] checksum
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CAPT    = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] cur_q,      cur_d;
  logic [ADDR_W-1:0] last_q,     last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [CSUM_W-1:0] csum_q,     csum_d;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    csum_d     = csum_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d   = first_addr;
          last_d  = last_addr;
          csum_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        out_data_d = rom_data;
        out_addr_d = cur_q;
        state_d    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          csum_d = csum_q + CSUM_W'(out_data_q);
          if (cur_q == last_q) begin
            state_d = ST_DONE;
          end else begin
            // cur only advances here, so it doubles as the held rom_addr
            cur_d   = cur_q + ADDR_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      last_q     <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      csum_q     <= csum_d;
    end
  end

  // Status outputs decode straight from state so they drop the instant reset asserts
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign rom_en    = (state_q == ST_ISSUE);
  assign out_valid = (state_q == ST_PRESENT);
  assign rom_addr  = cur_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign checksum  = csum_q;

endmodule

// File: tb/tb_rom_reader.sv
// tb/tb_rom_reader.sv - directed scoreboard bench for rom_reader
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] first_addr;
  logic [3:0] last_addr;
  logic       busy;
  logic       done;
  logic       rom_en;
  logic [3:0] rom_addr;
  logic [3:0] rom_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] out_addr;
  logic [7:0] checksum;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] q_addr[$];
  logic [3:0] q_data[$];

  always #5 clk = ~clk;

  // ROM model: registered read of addr ^ 4'b0101
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_addr ^ 4'b0101;
  end

  rom_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .checksum(checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one sweep. stall_word/stall_cycles inject backpressure; pulse_k pulses start
  // (with a different range) in that cycle of the sweep, which must be ignored.
  task automatic run_sweep(input string name, input logic [3:0] f, input logic [3:0] l,
                           input int stall_word, input int stall_cycles, input int pulse_k);
    int         n_words;
    logic [7:0] exp_csum;
    logic [3:0] a;
    int         word_idx;
    int         stall_left;
    int         en_count;
    bit         seen_done;

    n_words  = int'(4'(l - f)) + 1;
    exp_csum = 8'h00;
    a        = f;
    for (int i = 0; i < n_words; i++) begin
      q_addr.push_back(a);
      q_data.push_back(a ^ 4'b0101);
      exp_csum = exp_csum + {4'h0, a ^ 4'b0101};
      a = a + 4'd1;
    end

    @(negedge clk);
    start = 1'b1; first_addr = f; last_addr = l; out_ready = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0; first_addr = 4'hc; last_addr = 4'hd;
    check({name, " busy_after_start"}, busy, 1'b1);

    word_idx = 0; stall_left = stall_cycles; en_count = 0; seen_done = 0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      if (rom_en) en_count++;
      if (k == pulse_k) start = 1'b1;
      else if (k == pulse_k + 1) start = 1'b0;
      if (done) begin
        check({name, " done_cycle"}, k, 3 * n_words + stall_cycles);
        check({name, " checksum"}, checksum, exp_csum);
        check({name, " busy_in_done"}, busy, 1'b1);
        seen_done = 1;
        break;
      end
      if (out_valid) begin
        if (word_idx == stall_word && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          check({name, " stall_rom_en"}, rom_en, 1'b0);
          check({name, " stall_addr"}, out_addr, q_addr.size() > 0 ? q_addr[0] : 4'hx);
          check({name, " stall_data"}, out_data, q_data.size() > 0 ? q_data[0] : 4'hx);
        end else begin
          out_ready = 1'b1;
          if (q_addr.size() == 0) begin
            check({name, " extra_word"}, out_addr, 32'hffff_ffff);
          end else begin
            check({name, " out_addr"}, out_addr, q_addr.pop_front());
            check({name, " out_data"}, out_data, q_data.pop_front());
          end
          word_idx++;
        end
      end
      @(posedge clk);
    end
    if (!seen_done) check({name, " done_timeout"}, 0, 1);
    start = 1'b0; out_ready = 1'b1;
    check({name, " rom_reads"}, en_count, n_words);
    check({name, " words_left"}, q_addr.size(), 0);
    q_addr.delete(); q_data.delete();

    // checksum holds after completion, controller idle
    @(negedge clk);
    @(negedge clk);
    check({name, " idle_busy"}, busy, 1'b0);
    check({name, " csum_hold"}, checksum, exp_csum);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; first_addr = 4'h0; last_addr = 4'h0; out_ready = 1'b1;
    rom_data = 4'h0;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst rom_en", rom_en, 1'b0);
    check("rst out_valid", out_valid, 1'b0);
    check("rst checksum", checksum, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_sweep("full",   4'h0, 4'hf, -1, 0, -1);
    run_sweep("wrap",   4'ha, 4'h3, -1, 0, -1);
    run_sweep("single", 4'h6, 4'h6, -1, 0, -1);
    run_sweep("stall",  4'h0, 4'h3,  1, 5, -1);
    run_sweep("busy_start", 4'h4, 4'h7, -1, 0, 4);

    // reset while a word is being presented
    @(negedge clk);
    start = 1'b1; first_addr = 4'h0; last_addr = 4'h7; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    check("abort reached_present", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort rom_en", rom_en, 1'b0);
    check("abort out_valid", out_valid, 1'b0);
    check("abort rom_addr", rom_addr, 4'h0);
    check("abort out_data", out_data, 4'h0);
    check("abort out_addr", out_addr, 4'h0);
    check("abort checksum", checksum, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    begin
      bit any_done = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (done || busy) any_done = 1;
      end
      check("abort no_done", any_done, 1'b0);
    end

    run_sweep("after_rst", 4'h2, 4'h5, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
